// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and register-index widths.
// The register file and the pipeline stages both build their ports from these.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int NUM_GPRS = 1 << REG_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    function automatic logic is_zero_reg(input regbits_t sel);
        return (sel == '0);
    endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port's output select: hardwired zero for r0, else write-back data on
// a same-cycle index match, else the stored register value.
module rf_bypass_mux
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  regbits_t          rsel,
    input  regbits_t          wsel,
    input  logic              byp_en,
    input  logic [DATA_W-1:0] wdat,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rdat
);

    always_comb begin
        rdat = '0;
        if (!is_zero_reg(rsel)) begin
            if (byp_en && (rsel == wsel)) begin
                rdat = wdat;
            end else begin
                rdat = stored;
            end
        end
    end

endmodule

// File: rtl/register_file_wb.sv
// 32x32 GPR file fed by the write-back stage, with two combinational read ports
// and an optional same-cycle write-to-read bypass.
module register_file_wb
    import cpu_types_pkg::*;
#(
    parameter int          NREGS        = NUM_GPRS,
    parameter int          DATA_W       = WORD_W,
    parameter int          BYPASS_EN    = 1,
    // Reset value of the write counter; nonzero only to exercise wrap in simulation.
    parameter logic [31:0] WR_COUNT_RST = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        WEN,
    input  regbits_t    wsel,
    input  word_t       wdat,
    input  regbits_t    rsel1,
    input  regbits_t    rsel2,
    output word_t       rdat1,
    output word_t       rdat2,
    output logic [31:0] wr_count
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_valid;
    logic              byp_en;

    assign wr_valid = WEN && !is_zero_reg(wsel);

    // Bypass is held off during reset so reads return the cleared storage.
    assign byp_en = (BYPASS_EN != 0) && wr_valid && nRST;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= WR_COUNT_RST;
        end else if (wr_valid) begin
            regs[wsel] <= wdat;
            wr_count   <= wr_count + 32'd1;
        end
    end

    rf_bypass_mux #(.DATA_W(DATA_W)) u_port1 (
        .rsel   (rsel1),
        .wsel   (wsel),
        .byp_en (byp_en),
        .wdat   (wdat),
        .stored (regs[rsel1]),
        .rdat   (rdat1)
    );

    rf_bypass_mux #(.DATA_W(DATA_W)) u_port2 (
        .rsel   (rsel2),
        .wsel   (wsel),
        .byp_en (byp_en),
        .wdat   (wdat),
        .stored (regs[rsel2]),
        .rdat   (rdat2)
    );

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench: a bypassing instance and a non-bypassing instance (counter
// preset to all-ones) share one stimulus stream.
module tb_register_file_wb;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        WEN;
    regbits_t    wsel;
    word_t       wdat;
    regbits_t    rsel1;
    regbits_t    rsel2;
    word_t       rdat1_a, rdat2_a, rdat1_b, rdat2_b;
    logic [31:0] cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    register_file_wb #(.BYPASS_EN(1)) dut_a (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1_a), .rdat2(rdat2_a),
        .wr_count(cnt_a)
    );

    register_file_wb #(.BYPASS_EN(0), .WR_COUNT_RST(32'hFFFF_FFFF)) dut_b (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1_b), .rdat2(rdat2_b),
        .wr_count(cnt_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; WEN = 1'b0; wsel = '0; wdat = '0; rsel1 = '0; rsel2 = '0;
        #12;
        check("reset_rdat1", rdat1_a, 32'h0);
        check("reset_cnt_a", cnt_a, 32'h0);
        check("reset_cnt_b", cnt_b, 32'hFFFF_FFFF);
        nRST = 1'b1;

        // write r8, both ports read it
        WEN = 1'b1; wsel = 5'd8; wdat = 32'hDEAD_BEEF; rsel1 = 5'd8; rsel2 = 5'd8;
        #1;
        check("wr8_pre_byp_a", rdat1_a, 32'hDEAD_BEEF);
        check("wr8_pre_nobyp_b", rdat1_b, 32'h0);
        tick(); WEN = 1'b0; #1;
        check("wr8_rdat1_a", rdat1_a, 32'hDEAD_BEEF);
        check("wr8_rdat2_a", rdat2_a, 32'hDEAD_BEEF);
        check("wr8_rdat1_b", rdat1_b, 32'hDEAD_BEEF);
        check("wr8_cnt_a", cnt_a, 32'd1);
        check("wrap_cnt_b", cnt_b, 32'h0);

        // zero register ignores writes, bypass included
        WEN = 1'b1; wsel = 5'd0; wdat = 32'hFFFF_FFFF; rsel1 = 5'd0;
        #1;
        check("r0_pre_a", rdat1_a, 32'h0);
        check("r0_pre_b", rdat1_b, 32'h0);
        tick(); WEN = 1'b0; #1;
        check("r0_post_a", rdat1_a, 32'h0);
        check("r0_cnt_a", cnt_a, 32'd1);
        check("r0_cnt_b", cnt_b, 32'h0);

        // preload r3=1, r4=0x44, then bypass on port 1 only
        WEN = 1'b1; wsel = 5'd3; wdat = 32'h1; tick();
        wsel = 5'd4; wdat = 32'h44; tick();
        wsel = 5'd3; wdat = 32'hA5A5_A5A5; rsel1 = 5'd3; rsel2 = 5'd4;
        #1;
        check("byp_rdat1_a", rdat1_a, 32'hA5A5_A5A5);
        check("byp_rdat2_a", rdat2_a, 32'h44);
        check("nobyp_rdat1_b", rdat1_b, 32'h1);
        check("nobyp_rdat2_b", rdat2_b, 32'h44);
        tick(); WEN = 1'b0; #1;
        check("nobyp_post_b", rdat1_b, 32'hA5A5_A5A5);
        check("byp_cnt_a", cnt_a, 32'd4);

        // both ports bypass the same register
        WEN = 1'b1; wsel = 5'd9; wdat = 32'h99; rsel1 = 5'd9; rsel2 = 5'd9;
        #1;
        check("dual_byp1_a", rdat1_a, 32'h99);
        check("dual_byp2_a", rdat2_a, 32'h99);
        check("dual_nobyp_b", rdat2_b, 32'h0);
        tick(); WEN = 1'b0;

        // back-to-back writes to r31
        WEN = 1'b1; wsel = 5'd31; wdat = 32'h10; tick();
        wdat = 32'h20; tick();
        WEN = 1'b0; rsel1 = 5'd31; #1;
        check("b2b_rdat_a", rdat1_a, 32'h20);
        check("b2b_rdat_b", rdat1_b, 32'h20);
        check("b2b_cnt_a", cnt_a, 32'd7);

        // write r31 while port 1 reads an unrelated register
        WEN = 1'b1; wsel = 5'd31; wdat = 32'h30; rsel1 = 5'd8; rsel2 = 5'd31;
        #1;
        check("other_rdat1_a", rdat1_a, 32'hDEAD_BEEF);
        check("other_byp2_a", rdat2_a, 32'h30);
        check("other_old2_b", rdat2_b, 32'h20);
        tick(); WEN = 1'b0;

        // r5 then asynchronous reset with a write pending
        WEN = 1'b1; wsel = 5'd5; wdat = 32'h1234_5678; tick();
        WEN = 1'b0; rsel1 = 5'd5; #1;
        check("r5_rdat_a", rdat1_a, 32'h1234_5678);
        check("r5_cnt_a", cnt_a, 32'd9);
        WEN = 1'b1; wdat = 32'h0000_CAFE; nRST = 1'b0;
        #1;
        check("rst_rdat1_a", rdat1_a, 32'h0);
        check("rst_cnt_a", cnt_a, 32'h0);
        check("rst_cnt_b", cnt_b, 32'hFFFF_FFFF);
        tick();
        WEN = 1'b0; rsel2 = 5'd31;
        @(negedge CLK); nRST = 1'b1; #1;
        check("post_rst_r5_a", rdat1_a, 32'h0);
        check("post_rst_r31_b", rdat2_b, 32'h0);

        // second wrap on the preset counter
        WEN = 1'b1; wsel = 5'd1; wdat = 32'h7; tick(); WEN = 1'b0; #1;
        check("rewrap_cnt_b", cnt_b, 32'h0);
        check("rewrap_cnt_a", cnt_a, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
